// File: rtl/interface_controller_pkg.sv
// Shared stream-cipher definitions: interface FSM state encoding and default sizing.
// Imported by the interface controller, reader and router so all agree on the enum.
package interface_controller_pkg;

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    LOAD      = 2'd1,
    WAIT_CORE = 2'd2,
    ACK       = 2'd3
  } interface_state_t;

  localparam int unsigned TIMEOUT_CYCLES_DEFAULT = 255;
  localparam int unsigned COUNT_W_DEFAULT        = 16;

endpackage

// File: rtl/interface_controller_if.sv
// Pin/reader/core-facing signal bundle for the interface controller.
// master = controller side, slave = pins, reader and cipher core side.
interface interface_controller_if
  import interface_controller_pkg::*;
#(
  parameter int unsigned COUNT_W = COUNT_W_DEFAULT
) ();

  logic                   input_request;
  logic                   input_byte_pulse;
  logic                   is_key_pulsed;
  logic                   reset_hash_pulse;
  logic                   core_done;
  logic [7:0]             core_result;
  interface_state_t       fsm_state;
  logic                   input_ack;
  logic [7:0]             output_byte;
  logic                   output_valid;
  logic                   err;
  logic [COUNT_W-1:0]     byte_count;

  modport master (
    input  input_request, input_byte_pulse, is_key_pulsed, reset_hash_pulse,
    input  core_done, core_result,
    output fsm_state, input_ack, output_byte, output_valid, err, byte_count
  );

  modport slave (
    output input_request, input_byte_pulse, is_key_pulsed, reset_hash_pulse,
    output core_done, core_result,
    input  fsm_state, input_ack, output_byte, output_valid, err, byte_count
  );

endinterface

// File: rtl/interface_controller.sv
// 4-phase pin handshake sequencer for the stream cipher (IDLE/LOAD/WAIT_CORE/ACK).
// Define IFACE_CTRL_TIMEOUT_EN to bound WAIT_CORE to TIMEOUT_CYCLES cycles.
module interface_controller
  import interface_controller_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYCLES = TIMEOUT_CYCLES_DEFAULT,
  parameter int unsigned COUNT_W        = COUNT_W_DEFAULT
) (
  input  logic                    clk,
  input  logic                    nrst,
  interface_controller_if.master  bus
);

  interface_state_t   state_q,        state_d;
  logic               input_ack_q,    input_ack_d;
  logic [7:0]         output_byte_q,  output_byte_d;
  logic               output_valid_q, output_valid_d;
  logic               err_q,          err_d;
  logic [COUNT_W-1:0] byte_count_q,   byte_count_d;
  logic               timeout_hit;

`ifdef IFACE_CTRL_TIMEOUT_EN
  logic [15:0] to_cnt_q, to_cnt_d;

  // Counter restarts in LOAD so it is zero on the first WAIT_CORE cycle.
  always_comb begin
    to_cnt_d = to_cnt_q;
    if (state_q == LOAD) begin
      to_cnt_d = '0;
    end else if (state_q == WAIT_CORE) begin
      to_cnt_d = to_cnt_q + 16'd1;
    end
  end

  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      to_cnt_q <= '0;
    end else begin
      to_cnt_q <= to_cnt_d;
    end
  end

  assign timeout_hit = (to_cnt_q == 16'(TIMEOUT_CYCLES - 1));
`else
  logic unused_timeout_cfg;
  assign unused_timeout_cfg = |TIMEOUT_CYCLES;
  assign timeout_hit        = 1'b0;
`endif

  always_comb begin
    state_d        = state_q;
    output_byte_d  = output_byte_q;
    output_valid_d = output_valid_q;
    err_d          = err_q;
    byte_count_d   = byte_count_q;

    case (state_q)
      IDLE: begin
        if (bus.input_request) begin
          state_d = LOAD;
        end
      end
      LOAD: begin
        output_valid_d = 1'b0;
        if (bus.reset_hash_pulse) begin
          state_d = ACK;
        end else if (bus.input_byte_pulse && bus.is_key_pulsed) begin
          state_d = ACK;
        end else if (bus.input_byte_pulse) begin
          state_d = WAIT_CORE;
        end else begin
          state_d = ACK;
          err_d   = 1'b1;
        end
      end
      WAIT_CORE: begin
        // core_done wins over a timeout expiring in the same cycle.
        if (bus.core_done) begin
          state_d        = ACK;
          output_byte_d  = bus.core_result;
          output_valid_d = 1'b1;
          byte_count_d   = byte_count_q + COUNT_W'(1);
        end else if (timeout_hit) begin
          state_d        = ACK;
          err_d          = 1'b1;
          output_valid_d = 1'b0;
        end
      end
      ACK: begin
        if (!bus.input_request) begin
          state_d        = IDLE;
          output_valid_d = 1'b0;
          err_d          = 1'b0;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    input_ack_d = (state_d == ACK);
  end

  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      state_q        <= IDLE;
      input_ack_q    <= 1'b0;
      output_byte_q  <= '0;
      output_valid_q <= 1'b0;
      err_q          <= 1'b0;
      byte_count_q   <= '0;
    end else begin
      state_q        <= state_d;
      input_ack_q    <= input_ack_d;
      output_byte_q  <= output_byte_d;
      output_valid_q <= output_valid_d;
      err_q          <= err_d;
      byte_count_q   <= byte_count_d;
    end
  end

  assign bus.fsm_state    = state_q;
  assign bus.input_ack    = input_ack_q;
  assign bus.output_byte  = output_byte_q;
  assign bus.output_valid = output_valid_q;
  assign bus.err          = err_q;
  assign bus.byte_count   = byte_count_q;

endmodule

// File: tb/tb_interface_controller.sv
// Directed bench for interface_controller (COUNT_W=4 so the byte counter wraps quickly).
// Timeout cases run only when IFACE_CTRL_TIMEOUT_EN is defined.
module tb_interface_controller;
  import interface_controller_pkg::*;

  logic clk  = 1'b0;
  logic nrst = 1'b0;
  int   n_checks = 0;
  int   n_fail   = 0;
  logic [3:0] exp_cnt = 4'd0;

  interface_controller_if #(.COUNT_W(4)) bus ();

  interface_controller #(.TIMEOUT_CYCLES(8), .COUNT_W(4)) dut (
    .clk  (clk),
    .nrst (nrst),
    .bus  (bus)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
    $display("check %-16s observed %0h expected %0h", tag, obs, exp);
  endtask

  task automatic check_st(input string tag, input interface_state_t exp);
    check(tag, 32'(bus.fsm_state), 32'(exp));
  endtask

  // Complete data transaction starting from IDLE with request low.
  task automatic data_txn(input logic [7:0] res);
    bus.input_request = 1'b1;
    step();
    bus.input_byte_pulse = 1'b1;
    step();
    bus.input_byte_pulse = 1'b0;
    bus.core_done        = 1'b1;
    bus.core_result      = res;
    step();
    bus.core_done = 1'b0;
    exp_cnt = exp_cnt + 4'd1;
    check("txn_valid", 32'(bus.output_valid), 32'd1);
    check("txn_cnt",   32'(bus.byte_count),   32'(exp_cnt));
    bus.input_request = 1'b0;
    step();
    check_st("txn_idle", IDLE);
  endtask

  initial begin
    bus.input_request    = 1'b0;
    bus.input_byte_pulse = 1'b0;
    bus.is_key_pulsed    = 1'b0;
    bus.reset_hash_pulse = 1'b0;
    bus.core_done        = 1'b0;
    bus.core_result      = 8'h00;

    // Reset state
    repeat (2) @(posedge clk);
    #1;
    check_st("rst_state", IDLE);
    check("rst_ack",   32'(bus.input_ack),    32'd0);
    check("rst_byte",  32'(bus.output_byte),  32'd0);
    check("rst_valid", 32'(bus.output_valid), 32'd0);
    check("rst_err",   32'(bus.err),          32'd0);
    check("rst_cnt",   32'(bus.byte_count),   32'd0);
    nrst = 1'b1;
    step();

    // Data byte, core_done after 3 WAIT_CORE cycles
    bus.input_request = 1'b1;
    step();
    check_st("data_load", LOAD);
    bus.input_byte_pulse = 1'b1;
    step();
    bus.input_byte_pulse = 1'b0;
    check_st("data_wait", WAIT_CORE);
    check("data_wait_ack", 32'(bus.input_ack), 32'd0);
    step();
    step();
    check_st("data_wait3", WAIT_CORE);
    bus.core_done   = 1'b1;
    bus.core_result = 8'hA5;
    step();
    bus.core_done = 1'b0;
    exp_cnt = 4'd1;
    check_st("data_ack", ACK);
    check("data_ack_pin", 32'(bus.input_ack),    32'd1);
    check("data_byte",    32'(bus.output_byte),  32'hA5);
    check("data_valid",   32'(bus.output_valid), 32'd1);
    check("data_cnt",     32'(bus.byte_count),   32'd1);
    step();
    check_st("data_ack_hold", ACK);
    bus.input_request = 1'b0;
    step();
    check_st("data_idle", IDLE);
    check("data_idle_ack",   32'(bus.input_ack),    32'd0);
    check("data_idle_valid", 32'(bus.output_valid), 32'd0);
    check("data_byte_hold",  32'(bus.output_byte),  32'hA5);

    // Key byte goes straight to ACK
    bus.input_request = 1'b1;
    step();
    bus.input_byte_pulse = 1'b1;
    bus.is_key_pulsed    = 1'b1;
    step();
    bus.input_byte_pulse = 1'b0;
    bus.is_key_pulsed    = 1'b0;
    check_st("key_ack", ACK);
    check("key_valid", 32'(bus.output_valid), 32'd0);
    check("key_err",   32'(bus.err),          32'd0);
    check("key_cnt",   32'(bus.byte_count),   32'd1);
    bus.input_request = 1'b0;
    step();
    check_st("key_idle", IDLE);

    // Hash reset wins over a simultaneous data byte pulse
    bus.input_request = 1'b1;
    step();
    bus.reset_hash_pulse = 1'b1;
    bus.input_byte_pulse = 1'b1;
    step();
    bus.reset_hash_pulse = 1'b0;
    bus.input_byte_pulse = 1'b0;
    check_st("hash_ack", ACK);
    check("hash_valid", 32'(bus.output_valid), 32'd0);
    check("hash_cnt",   32'(bus.byte_count),   32'd1);
    bus.input_request = 1'b0;
    step();

    // No pulse in LOAD is a protocol fault; err clears on exit
    bus.input_request = 1'b1;
    step();
    step();
    check_st("fault_ack", ACK);
    check("fault_err", 32'(bus.err), 32'd1);
    bus.input_request = 1'b0;
    step();
    check_st("fault_idle", IDLE);
    check("fault_err_clr", 32'(bus.err), 32'd0);

    // Request dropped during LOAD: transaction still completes, ACK lasts one cycle
    bus.input_request = 1'b1;
    step();
    bus.input_request    = 1'b0;
    bus.input_byte_pulse = 1'b1;
    step();
    bus.input_byte_pulse = 1'b0;
    check_st("early_wait", WAIT_CORE);
    bus.core_done   = 1'b1;
    bus.core_result = 8'h3C;
    step();
    bus.core_done = 1'b0;
    exp_cnt = exp_cnt + 4'd1;
    check_st("early_ack", ACK);
    check("early_byte", 32'(bus.output_byte), 32'h3C);
    check("early_cnt",  32'(bus.byte_count),  32'(exp_cnt));
    step();
    check_st("early_idle", IDLE);

    // core_done outside WAIT_CORE is ignored
    bus.core_done   = 1'b1;
    bus.core_result = 8'hFF;
    step();
    bus.core_done = 1'b0;
    check_st("stray_state", IDLE);
    check("stray_cnt",  32'(bus.byte_count),  32'(exp_cnt));
    check("stray_byte", 32'(bus.output_byte), 32'h3C);

    // Fill counter to 15, then next completion wraps to 0
    while (exp_cnt != 4'd15) begin
      data_txn(8'(exp_cnt) + 8'h10);
    end
    check("pre_wrap_cnt", 32'(bus.byte_count), 32'd15);
    data_txn(8'h5A);
    check("wrap_cnt", 32'(bus.byte_count), 32'd0);

`ifdef IFACE_CTRL_TIMEOUT_EN
    // Timeout: 8 WAIT_CORE cycles without core_done
    bus.input_request = 1'b1;
    step();
    bus.input_byte_pulse = 1'b1;
    step();
    bus.input_byte_pulse = 1'b0;
    repeat (7) step();
    check_st("to_wait8", WAIT_CORE);
    step();
    check_st("to_ack", ACK);
    check("to_err",   32'(bus.err),          32'd1);
    check("to_valid", 32'(bus.output_valid), 32'd0);
    check("to_cnt",   32'(bus.byte_count),   32'(exp_cnt));
    bus.input_request = 1'b0;
    step();

    // core_done in the expiring cycle completes normally
    bus.input_request = 1'b1;
    step();
    bus.input_byte_pulse = 1'b1;
    step();
    bus.input_byte_pulse = 1'b0;
    repeat (7) step();
    bus.core_done   = 1'b1;
    bus.core_result = 8'h77;
    step();
    bus.core_done = 1'b0;
    exp_cnt = exp_cnt + 4'd1;
    check_st("to_race_ack", ACK);
    check("to_race_err",   32'(bus.err),          32'd0);
    check("to_race_valid", 32'(bus.output_valid), 32'd1);
    check("to_race_byte",  32'(bus.output_byte),  32'h77);
    bus.input_request = 1'b0;
    step();
`endif

    // Async reset during WAIT_CORE with request held
    bus.input_request = 1'b1;
    step();
    bus.input_byte_pulse = 1'b1;
    step();
    bus.input_byte_pulse = 1'b0;
    check_st("rw_wait", WAIT_CORE);
    nrst = 1'b0;
    #1;
    check_st("rw_idle", IDLE);
    check("rw_ack", 32'(bus.input_ack),  32'd0);
    check("rw_cnt", 32'(bus.byte_count), 32'd0);
    exp_cnt = 4'd0;
    #2;
    nrst = 1'b1;
    step();
    check_st("rw_reload", LOAD);

    // Async reset during ACK with request held
    bus.input_byte_pulse = 1'b1;
    step();
    bus.input_byte_pulse = 1'b0;
    bus.core_done        = 1'b1;
    bus.core_result      = 8'hC3;
    step();
    bus.core_done = 1'b0;
    check_st("ra_ack", ACK);
    check("ra_cnt", 32'(bus.byte_count), 32'd1);
    nrst = 1'b0;
    #1;
    check_st("ra_idle", IDLE);
    check("ra_ack_pin", 32'(bus.input_ack),    32'd0);
    check("ra_valid",   32'(bus.output_valid), 32'd0);
    check("ra_byte",    32'(bus.output_byte),  32'd0);
    #2;
    nrst = 1'b1;
    step();
    check_st("ra_reload", LOAD);
    bus.input_request = 1'b0;
    step();
    step();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
